// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - RF write-port arbiter and busy scoreboard; RF_WB_RR_EN selects round-robin over fixed priority
module rf_wb_arb #(
    parameter int NSRC = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSRC-1:0]    req,
    input  logic [NSRC*AW-1:0] req_addr,
    input  logic [NSRC*DW-1:0] req_data,
    output logic [NSRC-1:0]    gnt,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_addr,
    input  logic [AW-1:0]      chk_addr0,
    input  logic [AW-1:0]      chk_addr1,
    output logic               hazard,
    output logic [31:0]        busy,
    output logic               iss_conflict,
    output logic               we,
    output logic [AW-1:0]      dst_addr,
    output logic [DW-1:0]      dst
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [SW-1:0] win;
    logic [SW-1:0] cand;
    logic          found;
    logic          accept;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic [31:0]   busy_nxt;
    logic          iss_live;

`ifdef RF_WB_RR_EN
    logic [SW-1:0] ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(win) == NSRC - 1) ? '0 : win + 1'b1;
        end
    end
`endif

    // Priority search; in round-robin mode it starts at the pointer and wraps.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
`ifdef RF_WB_RR_EN
            cand = SW'((int'(ptr) + k) % NSRC);
`else
            cand = SW'(k);
`endif
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        accept = found & rst_n;
        gnt    = '0;
        if (accept) begin
            gnt[win] = 1'b1;
        end
    end

    assign acc_addr = req_addr[win*AW +: AW];
    assign acc_data = req_data[win*DW +: DW];
    assign iss_live = iss_valid && (iss_addr != '0);

    // A new issue overrides a retiring write to the same register.
    always_comb begin
        busy_nxt = busy;
        if (accept) begin
            busy_nxt[acc_addr] = 1'b0;
        end
        if (iss_live) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we           <= 1'b0;
            dst_addr     <= '0;
            dst          <= '0;
            busy         <= '0;
            iss_conflict <= 1'b0;
        end else begin
            we           <= accept && (acc_addr != '0);
            busy         <= busy_nxt;
            iss_conflict <= iss_live && busy[iss_addr];
            if (accept) begin
                dst_addr <= acc_addr;
                dst      <= acc_data;
            end
        end
    end

    assign hazard = ((chk_addr0 != '0) && busy[chk_addr0]) ||
                    ((chk_addr1 != '0) && busy[chk_addr1]);

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - scoreboard bench for rf_wb_arb against a behavioural model
module tb_rf_wb_arb;

    localparam int NSRC = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

`ifdef RF_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NSRC-1:0]    req;
    logic [NSRC*AW-1:0] req_addr;
    logic [NSRC*DW-1:0] req_data;
    logic [NSRC-1:0]    gnt;
    logic               iss_valid;
    logic [AW-1:0]      iss_addr;
    logic [AW-1:0]      chk_addr0;
    logic [AW-1:0]      chk_addr1;
    logic               hazard;
    logic [31:0]        busy;
    logic               iss_conflict;
    logic               we;
    logic [AW-1:0]      dst_addr;
    logic [DW-1:0]      dst;

    always #5 clk = ~clk;

    rf_wb_arb #(.NSRC(NSRC), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .iss_valid(iss_valid), .iss_addr(iss_addr), .chk_addr0(chk_addr0),
        .chk_addr1(chk_addr1), .hazard(hazard), .busy(busy), .iss_conflict(iss_conflict),
        .we(we), .dst_addr(dst_addr), .dst(dst)
    );

    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];
    wr_t me;
    int  wins[$];
    bit  rec_wins = 1'b0;

    bit [31:0]     m_busy = '0;
    int            m_ptr  = 0;
    bit            m_conf = 1'b0;
    bit            reg_en = 1'b0;
    bit            pend[NSRC];
    logic [AW-1:0] paddr[NSRC];
    logic [DW-1:0] pdata[NSRC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NSRC-1:0] r);
        for (int k = 0; k < NSRC; k++) begin
            int i = RR ? (m_ptr + k) % NSRC : k;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]  = 1'b1;
        paddr[i] = a;
        pdata[i] = d;
    endtask

    // One clock: check last edge's registered state, drive, check comb outputs, advance model.
    task automatic step(input bit rv, input bit iv, input logic [AW-1:0] ia,
                        input logic [AW-1:0] c0, input logic [AW-1:0] c1);
        int            w;
        logic [NSRC-1:0] eg;
        bit [31:0]     nb;
        wr_t           e;
        @(posedge clk);
        #1;
        if (reg_en) begin
            chk("busy", busy, m_busy);
            chk("iss_conflict", iss_conflict, m_conf);
        end
        rst_n     = rv;
        iss_valid = iv;
        iss_addr  = ia;
        chk_addr0 = c0;
        chk_addr1 = c1;
        for (int i = 0; i < NSRC; i++) begin
            req[i]                = pend[i];
            req_addr[i*AW +: AW]  = paddr[i];
            req_data[i*DW +: DW]  = pdata[i];
        end
        #4;
        w  = rv ? pick(req) : -1;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", gnt, eg);
        chk("hazard", hazard, (c0 != 0 && m_busy[c0]) || (c1 != 0 && m_busy[c1]));
        e = '0;
        if (!rv) begin
            m_busy = '0;
            m_ptr  = 0;
            m_conf = 1'b0;
            reg_en = 1'b1;
            for (int i = 0; i < NSRC; i++) pend[i] = 1'b0;
        end else begin
            nb     = m_busy;
            m_conf = iv && ia != 0 && m_busy[ia];
            if (w >= 0) begin
                nb[paddr[w]] = 1'b0;
                if (paddr[w] != 0) begin
                    e.v = 1'b1;
                    e.a = paddr[w];
                    e.d = pdata[w];
                end
                m_ptr   = (w + 1) % NSRC;
                pend[w] = 1'b0;
                if (rec_wins) wins.push_back(w);
            end
            if (iv && ia != 0) nb[ia] = 1'b1;
            m_busy = nb;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [AW-1:0] c0);
        step(1'b1, 1'b0, '0, c0, '0);
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            chk("we", we, me.v);
            if (me.v) begin
                chk("dst_addr", dst_addr, me.a);
                chk("dst", dst, me.d);
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; iss_valid = 1'b0; iss_addr = '0; chk_addr0 = '0; chk_addr1 = '0;
        req = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
        end

        step(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        repeat (3) idle('0);

        post(1, 5'd7, 32'hDEADBEEF);
        idle('0);
        repeat (2) idle('0);

        step(1'b0, 1'b0, '0, '0, '0);
        rec_wins = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NSRC; i++)
                if (!pend[i]) post(i, AW'(10 + i + 3 * c), $urandom);
            idle('0);
        end
        rec_wins = 1'b0;
        repeat (4) idle('0);
        chk("win_count", wins.size(), 6);
        for (int k = 0; k < wins.size() && k < 6; k++)
            chk("contention_order", wins[k], RR ? k % NSRC : 0);

        step(1'b1, 1'b1, 5'd5, 5'd5, '0);
        repeat (2) idle(5'd5);
        post(2, 5'd5, 32'h0000_5555);
        idle(5'd5);
        idle(5'd5);
        step(1'b1, 1'b1, 5'd5, '0, 5'd5);
        post(2, 5'd5, 32'h5555_0000);
        step(1'b1, 1'b1, 5'd5, 5'd5, '0);
        repeat (2) idle(5'd5);
        post(0, 5'd5, 32'h1234_5678);
        idle(5'd5);

        step(1'b1, 1'b1, 5'd0, 5'd0, '0);
        post(0, 5'd0, 32'hFFFF_FFFF);
        idle('0);
        step(1'b1, 1'b1, 5'd9, 5'd9, '0);
        step(1'b1, 1'b1, 5'd9, 5'd9, '0);
        repeat (2) idle(5'd9);
        post(1, 5'd9, 32'h0909_0909);
        idle(5'd9);

        step(1'b1, 1'b1, 5'd3, 5'd3, '0);
        post(1, 5'd3, 32'h3333_3333);
        step(1'b0, 1'b0, '0, 5'd3, '0);
        repeat (2) idle(5'd3);

        repeat (400) begin
            for (int i = 0; i < NSRC; i++)
                if (!pend[i] && ($urandom % 2 == 0)) post(i, AW'($urandom), $urandom);
            step(($urandom % 97) != 0, ($urandom % 3) == 0, AW'($urandom),
                 AW'($urandom), AW'($urandom));
        end

        guard = 0;
        while ((pend[0] || pend[1] || pend[2]) && guard < 20) begin
            idle('0);
            guard++;
        end
        chk("drain_bound", guard < 20, 1'b1);
        repeat (2) idle('0);
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-port arbiter and scoreboard for the 32x32 triple-ported register file. It shares the single RF write port (we/dst_addr/dst) between several writeback sources: ALU, load return and multi-cycle mul/div. It tracks destination registers with writes still in flight. It also flags read-after-write hazards on the two RF read addresses, so decode can stall.

## Interface
- NSRC, 3: number of writeback sources; source 0 is the ALU.
- AW, 5: register address width (32 registers).
- DW, 32: data width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NSRC  per-source write request.
- req_addr  in  NSRC*AW  flattened destination addresses; source i at [i*AW +: AW].
- req_data  in  NSRC*DW  flattened write data; source i at [i*DW +: DW].
- gnt  out  NSRC  one-hot grant, combinational from req and arbiter state.
- iss_valid  in  1  long-latency instruction issued; mark iss_addr busy.
- iss_addr  in  AW  destination of issued instruction.
- chk_addr0, chk_addr1  in  AW each  RF read addresses (p0/p1) to check.
- hazard  out  1  combinational: either chk address is busy.
- busy  out  32  scoreboard vector, registered.
- iss_conflict  out  1  registered one-cycle pulse: issue hit an already-busy register.
- we  out  1  registered RF write enable.
- dst_addr  out  AW  registered RF write address.
- dst  out  DW  registered RF write data.

## Operation
- Arbiter: at most one gnt bit high per cycle, and gnt[i] only when req[i]=1. A source is accepted on a rising edge where req[i]&gnt[i]. The source holds req/addr/data until accepted.
- Arbitration policy is selected by the macro (see Configuration).
- Accepted write: we<=1, dst_addr<=req_addr[i], dst<=req_data[i]. With no acceptance, we<=0. dst_addr and dst hold their last value.
- Writes to r0 are accepted and granted normally but drive we<=0. r0 stays zero.
- Scoreboard set: iss_valid with iss_addr!=0 sets busy[iss_addr]. iss_addr=0 is ignored.
- Scoreboard clear: an accepted write clears busy[addr] on the same edge.
- Set and clear to the same address on the same edge: set wins, because a new producer is in flight.
- Issue to an already-busy address: busy stays set and iss_conflict<=1 for one cycle.
- busy[0] is always 0.
- hazard = (chk_addr0!=0 & busy[chk_addr0]) | (chk_addr1!=0 & busy[chk_addr1]).
- ALU (source 0) writes also clear busy. Single-cycle ops need not set busy.

## Timing
- Reset (rst_n=0 at rising edge) forces:
  - we=0, dst_addr=0, dst=0.
  - busy=0, iss_conflict=0.
  - round-robin pointer to source 0.
- During reset cycles, gnt is forced to 0.
- Reset mid-operation drops all pending requests and in-flight marks. No write is issued from a request presented in the reset cycle.
- Latency: request accepted at edge N. we/dst_addr/dst are valid for exactly cycle N..N+1, i.e. one clock. The RF captures the write in the clk-high phase of that cycle.
- busy clears at edge N. A read checked in cycle N+1 sees hazard=0, and the RF low-phase read in that cycle returns the new value.
- Back-to-back acceptance is allowed every cycle, giving throughput of one write/cycle.
- hazard and gnt are purely combinational: no registered path from req to gnt.

## Configuration
- RF_WB_RR_EN defined: round-robin arbitration.
  - The pointer advances to (winner+1) mod NSRC after each acceptance and holds when idle.
  - Priority search starts at the pointer.
  - Any continuously requesting source is granted within NSRC cycles.
- RF_WB_RR_EN undefined: fixed priority, lowest index wins (source 0 highest).
  - No pointer register is implemented.
  - Starvation of higher indices is permitted.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles. Then we=0, busy=0, gnt=0, iss_conflict=0. After release with req=0, outputs stay 0.
- Single write: req=3'b010, addr 7, data 0xDEADBEEF. Expect gnt=3'b010 that cycle, and we=1, dst_addr=7, dst=0xDEADBEEF the next cycle only.
- Contention: req=3'b111 held with distinct addrs for 6 cycles.
  - RR build: grant order 0,1,2,0,1,2.
  - Fixed build: source 0 is granted every cycle.
- Scoreboard: iss_valid with addr 5, then chk_addr0=5.
  - Expect hazard=1 until source 2 writes addr 5. hazard=0 the cycle after acceptance.
  - A simultaneous iss to 5 on the accept edge keeps busy[5]=1.
- Edge cases:
  - iss_addr=0 leaves busy=0.
  - An accepted write to r0 gives gnt=1 but we=0.
  - A second iss to busy addr 9 pulses iss_conflict=1 for one cycle.
- Reset mid-operation: busy[3]=1 and req pending, then assert rst_n=0 for one cycle. Expect busy=0, we=0, no write.
